// File: rtl/rom_arbiter_pkg.sv
// Shared types and constants for the instruction-ROM arbiter.
//   PORT_IF / PORT_LS  : requester identity, used for the round-robin pointer
//   rsp_t              : one response entry {valid, err, data}
//   ROM_BASE_DEF       : default value of addr[31:16] for a ROM access
//   addr_err()         : range / alignment check applied at grant time
package rom_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [15:0] ROM_BASE_DEF = 16'h0040;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_LS = 1'b1
    } port_e;

    typedef struct packed {
        logic              valid;
        logic              err;
        logic [DATA_W-1:0] data;
    } rsp_t;

    function automatic logic addr_err(input logic [ADDR_W-1:0] addr,
                                      input logic [15:0]       base);
        return (addr[31:16] != base) || (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// Bus bundle between the two ROM requesters, the ROM and the arbiter.
//   if_*   : fetch port request/grant and response channel
//   ls_*   : load port, same set of signals
//   rom_*  : synchronous-read ROM address out, data back one cycle later
// Modports: slave = arbiter side, master = requesters + ROM side.
interface rom_arbiter_if;
    import rom_arb_pkg::*;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              if_err;
    logic              if_rready;

    logic              ls_req;
    logic [ADDR_W-1:0] ls_addr;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;
    logic              ls_err;
    logic              ls_rready;

    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    modport slave (
        input  if_req, if_addr, if_rready,
        input  ls_req, ls_addr, ls_rready,
        input  rom_data,
        output if_gnt, if_rvalid, if_rdata, if_err,
        output ls_gnt, ls_rvalid, ls_rdata, ls_err,
        output rom_addr
    );

    modport master (
        output if_req, if_addr, if_rready,
        output ls_req, ls_addr, ls_rready,
        output rom_data,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
        input  rom_addr
    );

endinterface

// File: rtl/rom_arbiter_rsp_slot.sv
// Per-port response slot: pending flag for the access granted last cycle,
// a one-entry hold register for back-pressure, and the output mux.
//   clk, rst_n       : clock, async active-low reset
//   grant, grant_err : port granted this cycle, and whether that access errs
//   rom_data         : ROM read data (valid the cycle after the grant)
//   rready           : requester accepts the response this cycle
//   eligible         : port may be granted this cycle
//   rvalid/err/rdata : response to the requester
module rom_arb_rsp_slot
    import rom_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              grant,
    input  logic              grant_err,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              rready,
    output logic              eligible,
    output logic              rvalid,
    output logic              err,
    output logic [DATA_W-1:0] rdata
);

    logic pend_q;
    logic pend_err_q;
    rsp_t hold_q;
    rsp_t live;
    rsp_t out;

    // Pending and hold are mutually exclusive: a pending entry either retires
    // or moves into hold, and a new grant needs the current one consumed.
    always_comb begin
        live.valid = pend_q;
        live.err   = pend_err_q;
        live.data  = pend_err_q ? '0 : rom_data;
        out        = hold_q.valid ? hold_q : live;
    end

    assign rvalid = out.valid;
    assign err    = out.valid & out.err;
    assign rdata  = out.valid ? out.data : '0;

    // A response retiring this cycle frees the slot for a same-cycle grant.
    assign eligible = !rvalid || rready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= 1'b0;
            pend_err_q <= 1'b0;
            hold_q     <= '0;
        end else begin
            pend_q     <= grant;
            pend_err_q <= grant & grant_err;
            if (pend_q && !rready) begin
                hold_q <= live;
            end else if (hold_q.valid && rready) begin
                hold_q <= '0;
            end
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing a synchronous-read instruction ROM between the
// fetch (IF) and load (LS) ports. At most one grant per cycle; each response
// returns one cycle after its grant through a per-port response slot.
//   clk_i : clock
//   rst_i : asynchronous active-low reset
//   bus   : rom_arbiter_if.slave (both requester ports and the ROM)
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter logic [15:0] ROM_BASE = ROM_BASE_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    rom_arbiter_if.slave bus
);

    logic              if_elig;
    logic              ls_elig;
    logic              if_win;
    logic              ls_win;
    port_e             last_q;
    logic [ADDR_W-1:0] addr_q;

    // last_q holds the most recent winner; IF wins a tie when it was LS.
    always_comb begin
        if_win = bus.if_req && if_elig &&
                 (!(bus.ls_req && ls_elig) || (last_q == PORT_LS));
        ls_win = bus.ls_req && ls_elig && !if_win;
    end

    assign bus.if_gnt   = if_win;
    assign bus.ls_gnt   = ls_win;
    // Hold the last granted address so the ROM output stays stable.
    assign bus.rom_addr = if_win ? bus.if_addr :
                          ls_win ? bus.ls_addr : addr_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_q <= PORT_LS;  // so IF wins the first tie
            addr_q <= '0;
        end else if (if_win || ls_win) begin
            last_q <= if_win ? PORT_IF : PORT_LS;
            addr_q <= bus.rom_addr;
        end
    end

    rom_arb_rsp_slot u_if_slot (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .grant     (if_win),
        .grant_err (addr_err(bus.if_addr, ROM_BASE)),
        .rom_data  (bus.rom_data),
        .rready    (bus.if_rready),
        .eligible  (if_elig),
        .rvalid    (bus.if_rvalid),
        .err       (bus.if_err),
        .rdata     (bus.if_rdata)
    );

    rom_arb_rsp_slot u_ls_slot (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .grant     (ls_win),
        .grant_err (addr_err(bus.ls_addr, ROM_BASE)),
        .rom_data  (bus.rom_data),
        .rready    (bus.ls_rready),
        .eligible  (ls_elig),
        .rvalid    (bus.ls_rvalid),
        .err       (bus.ls_err),
        .rdata     (bus.ls_rdata)
    );

endmodule
